rv32_dmem_ahb_master: RTL and testbench



---
 rtl/rv32_dmem_pkg.sv | 10 +
 rtl/rv32_store_align.sv | 15 +
 rtl/rv32_dmem_ahb_master.sv | 91 +++++++++
 tb/tb_rv32_dmem_ahb_master.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_dmem_pkg.sv
// rv32_dmem_pkg: shared encodings for the RV32I data-memory AHB-Lite master.
package rv32_dmem_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
endpackage

// File: rtl/rv32_store_align.sv
// rv32_store_align: misalignment detect and store-data byte-lane replication.
module rv32_store_align
  import rv32_dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] wdata_rep
);
  always_comb begin
    misaligned = (size == SZ_HALF) ? addr_lo[0] : (size == SZ_WORD) ? |addr_lo : (size != SZ_BYTE);
    wdata_rep = (size == SZ_BYTE) ? {4{wdata[7:0]}} : (size == SZ_HALF) ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/rv32_dmem_ahb_master.sv
// rv32_dmem_ahb_master: single-transfer AHB-Lite data master feeding the RV32I load unit.
module rv32_dmem_ahb_master
  import rv32_dmem_pkg::*;
#(
  parameter logic [3:0] HPROT_DATA = 4'b0011,
  parameter int WAIT_TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  input  logic        req_we_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_rdata_out,
  output logic [1:0]  rsp_addr_1to0_out,
  output logic        rsp_err_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [2:0]  hburst_out,
  output logic [3:0]  hprot_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);
  state_t state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic mis, timeout, err_nxt;
  logic [31:0] wdata_rep;
  rv32_store_align u_align (
    .size(req_size_in),
    .addr_lo(req_addr_in[1:0]),
    .wdata(req_wdata_in),
    .misaligned(mis),
    .wdata_rep(wdata_rep)
  );
  // fires on the cycle that would be the WAIT_TIMEOUT-th consecutive stalled cycle
  assign timeout = (WAIT_TIMEOUT != 0) && !hready_in && (wait_cnt == TO_W'(WAIT_TIMEOUT - 1));
  assign hburst_out = HBURST_SINGLE;
  assign hprot_out = HPROT_DATA;
  always_comb begin
    state_nxt = state;
    err_nxt = 1'b1;
    stall_out = ((state == IDLE) && req_valid_in && !mis) || (state == ADDR) || (state == DATA) || (state == ERR);
    misaligned_out = req_valid_in && (state == IDLE) && mis;
    htrans_out = (state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    rsp_valid_out = (state == RESP);
    case (state)
      IDLE: state_nxt = (req_valid_in && !mis) ? ADDR : IDLE;
      ADDR: state_nxt = hready_in ? DATA : timeout ? RESP : ADDR;
      DATA: begin
        state_nxt = hready_in ? RESP : hresp_in ? ERR : timeout ? RESP : DATA;
        err_nxt = hresp_in || !hready_in;
      end
      ERR: state_nxt = hready_in ? RESP : ERR;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      wait_cnt <= '0;
      haddr_out <= '0;
      hwrite_out <= 1'b0;
      hsize_out <= '0;
      hwdata_out <= '0;
      rsp_err_out <= 1'b0;
      rsp_rdata_out <= '0;
      rsp_addr_1to0_out <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= (state_nxt != state) ? '0 : (((state == ADDR) || (state == DATA)) && !hready_in) ? wait_cnt + 1'b1 : wait_cnt;
      if (state == IDLE && state_nxt == ADDR) begin
        haddr_out <= req_addr_in;
        hwrite_out <= req_we_in;
        hsize_out <= {1'b0, req_size_in};
        hwdata_out <= req_we_in ? wdata_rep : '0;
        rsp_addr_1to0_out <= req_addr_in[1:0];
      end
      if (state_nxt == RESP && state != RESP) rsp_err_out <= err_nxt;
      if (state == DATA && hready_in && !hresp_in && !hwrite_out) rsp_rdata_out <= hrdata_in;
    end
  end
endmodule

// File: tb/tb_rv32_dmem_ahb_master.sv
// tb_rv32_dmem_ahb_master: directed vector table plus hand sequences for error, timeout and reset.
module tb_rv32_dmem_ahb_master;
  import rv32_dmem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, hready = 1'b1, hresp = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, hrdata = '0;
  logic [1:0] req_size = '0;
  logic stall_out, misaligned_out, rsp_valid_out, rsp_err_out, hwrite_out;
  logic [31:0] rsp_rdata_out, haddr_out, hwdata_out;
  logic [1:0] rsp_addr_1to0_out, htrans_out;
  logic [2:0] hsize_out, hburst_out;
  logic [3:0] hprot_out;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rv32_dmem_ahb_master #(.WAIT_TIMEOUT(4)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_we_in(req_we), .req_addr_in(req_addr),
    .req_wdata_in(req_wdata), .req_size_in(req_size),
    .stall_out(stall_out), .misaligned_out(misaligned_out),
    .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out),
    .rsp_addr_1to0_out(rsp_addr_1to0_out), .rsp_err_out(rsp_err_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hburst_out(hburst_out), .hprot_out(hprot_out),
    .hwdata_out(hwdata_out), .hrdata_in(hrdata), .hready_in(hready), .hresp_in(hresp)
  );
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          waits;
    logic        mis;
    logic [31:0] hwdata;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_htrans"}, 32'(htrans_out), 0);
    chk({tag, "_haddr"}, haddr_out, 0);
    chk({tag, "_hwrite"}, 32'(hwrite_out), 0);
    chk({tag, "_hsize"}, 32'(hsize_out), 0);
    chk({tag, "_hwdata"}, hwdata_out, 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_out), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_out), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_out, 0);
    chk({tag, "_rsp_addr"}, 32'(rsp_addr_1to0_out), 0);
    chk({tag, "_stall"}, 32'(stall_out), 0);
  endtask
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    hready = 1'b1; hresp = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int cyc;
    logic done;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size; req_wdata = v.wdata;
    hrdata = v.hrdata; hready = 1'b1; hresp = 1'b0;
    #1;
    chk("misaligned", 32'(misaligned_out), 32'(v.mis));
    chk("stall_req", 32'(stall_out), 32'(!v.mis));
    if (v.mis) begin
      chk("htrans_mis", 32'(htrans_out), 32'(HTRANS_IDLE));
      @(negedge clk);
      chk("htrans_mis_next", 32'(htrans_out), 32'(HTRANS_IDLE));
      req_valid = 1'b0;
      return;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("htrans_addr", 32'(htrans_out), 32'(HTRANS_NONSEQ));
        chk("haddr", haddr_out, v.addr);
        chk("hwrite", 32'(hwrite_out), 32'(v.we));
        chk("hsize", 32'(hsize_out), 32'({1'b0, v.size}));
        chk("hburst", 32'(hburst_out), 32'(HBURST_SINGLE));
        chk("hprot", 32'(hprot_out), 32'h3);
      end
      if (cyc == 2) begin
        chk("htrans_data", 32'(htrans_out), 32'(HTRANS_IDLE));
        if (v.we) chk("hwdata", hwdata_out, v.hwdata);
      end
      if (rsp_valid_out) begin
        done = 1'b1;
        chk("latency", 32'(cyc), 32'(3 + v.waits));
        chk("rsp_rdata", rsp_rdata_out, v.rdata);
        chk("rsp_addr", 32'(rsp_addr_1to0_out), 32'(v.addr[1:0]));
        chk("rsp_err", 32'(rsp_err_out), 0);
        chk("stall_resp", 32'(stall_out), 0);
      end else chk("stall_busy", 32'(stall_out), 1);
      req_valid = 1'b0;
      hready = (cyc >= 2 && cyc < 2 + v.waits) ? 1'b0 : 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within 20 cycles, required %0d", 3 + v.waits);
    end
    hready = 1'b1;
  endtask
  initial begin
    vecs[0] = '{1'b0, 32'h100, SZ_WORD, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h203, SZ_BYTE, 32'h000000A5, 32'h11111111, 0, 1'b0, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h104, SZ_WORD, 32'h0, 32'h12345678, 3, 1'b0, 32'h0, 32'h12345678};
    vecs[3] = '{1'b1, 32'h302, SZ_HALF, 32'hFFFFBEEF, 32'h22222222, 0, 1'b0, 32'hBEEFBEEF, 32'h12345678};
    vecs[4] = '{1'b1, 32'h400, SZ_WORD, 32'hCAFEF00D, 32'h33333333, 1, 1'b0, 32'hCAFEF00D, 32'h12345678};
    vecs[5] = '{1'b0, 32'h101, SZ_HALF, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 32'h102, SZ_WORD, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 32'h200, 2'b11, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 32'h002, SZ_BYTE, 32'h0, 32'hAABBCCDD, 1, 1'b0, 32'h0, 32'hAABBCCDD};
    vecs[9] = '{1'b0, 32'h106, SZ_HALF, 32'h0, 32'h55667788, 2, 1'b0, 32'h0, 32'h55667788};
    repeat (3) @(negedge clk);
    check_reset_state("init");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    // ERROR with wait state: DATA -> ERR -> RESP
    issue(1'b0, 32'h500, SZ_WORD, 32'h0);
    @(negedge clk);
    hresp = 1'b1; hready = 1'b0;
    @(negedge clk);
    chk("err_stall", 32'(stall_out), 1);
    chk("err_no_valid", 32'(rsp_valid_out), 0);
    hready = 1'b1;
    @(negedge clk);
    chk("err_valid", 32'(rsp_valid_out), 1);
    chk("err_flag", 32'(rsp_err_out), 1);
    chk("err_stall_resp", 32'(stall_out), 0);
    hresp = 1'b0;
    // ERROR with hready high in DATA goes straight to RESP without capturing data
    hrdata = 32'h99999999;
    issue(1'b0, 32'h504, SZ_WORD, 32'h0);
    @(negedge clk);
    hresp = 1'b1; hready = 1'b1;
    @(negedge clk);
    chk("viol_valid", 32'(rsp_valid_out), 1);
    chk("viol_flag", 32'(rsp_err_out), 1);
    chk("viol_rdata_hold", rsp_rdata_out, 32'h55667788);
    hresp = 1'b0;
    // timeout: hready stuck low in ADDR for 4 cycles
    issue(1'b0, 32'h600, SZ_WORD, 32'h0);
    hready = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_htrans_last", 32'(htrans_out), 32'(HTRANS_NONSEQ));
    chk("to_no_valid", 32'(rsp_valid_out), 0);
    @(negedge clk);
    chk("to_valid", 32'(rsp_valid_out), 1);
    chk("to_flag", 32'(rsp_err_out), 1);
    chk("to_htrans", 32'(htrans_out), 32'(HTRANS_IDLE));
    hready = 1'b1;
    // reset during DATA abandons the transfer
    issue(1'b1, 32'h703, SZ_BYTE, 32'h5A);
    @(negedge clk);
    hready = 1'b0;
    chk("rst_pre_stall", 32'(stall_out), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid_out), 0);
    run_vec(vecs[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
